// File: rtl/cpu_id.sv
// cpu_id: instruction decoder for the single-cycle CPU; drives all datapath controls from IN.
module cpu_id #(
  parameter int WIDTH          = 13,
  parameter int IWIDTH         = 5,
  parameter int REG_F_SEL_SIZE = 4,
  parameter int IN_B_SEL_SIZE  = 2
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [WIDTH-1:0]          IN,
  output logic                      PC_RST,
  output logic                      PC_LD,
  output logic [1:0]                JMP_MODE,
  output logic [IWIDTH-2:0]         ALU_OUT,
  output logic [WIDTH-IWIDTH-1:0]   IMM,
  output logic [IN_B_SEL_SIZE-1:0]  IN_B_SEL,
  output logic [REG_F_SEL_SIZE-1:0] REG_F_SEL,
  output logic                      EN_REG_F,
  output logic [WIDTH-IWIDTH-1:0]   D_MEM_ADDR,
  output logic                      D_MEM_ADDR_MODE,
  output logic                      EN_D_MEM,
  output logic                      EN_ACC,
  output logic [WIDTH-IWIDTH-1:0]   BASE_REG_OFFSET,
  output logic                      BASE_REG_LD,
  output logic [WIDTH-IWIDTH-1:0]   BASE_REG_DATA,
  output logic                      LR_LD
);
  localparam int OW = WIDTH - IWIDTH;
  localparam logic [IWIDTH-1:0] OP_NOP  = 5'h00, OP_RST  = 5'h01, OP_LD   = 5'h02, OP_ST   = 5'h03,
                                OP_LDR  = 5'h04, OP_STR  = 5'h05, OP_BAR  = 5'h06, OP_JMP  = 5'h07,
                                OP_JMPO = 5'h08, OP_LDI  = 5'h09, OP_LDAR = 5'h0A, OP_XORR = 5'h0B,
                                OP_ORR  = 5'h0C, OP_ANDR = 5'h0D, OP_ADDR = 5'h0E, OP_SUBR = 5'h0F,
                                OP_CALL = 5'h10, OP_RET  = 5'h11;
  logic [IWIDTH-1:0] opc;
  logic [OW-1:0]     op;
  logic              link_valid_q, link_valid_d;
  assign opc             = IN[WIDTH-1:OW];
  assign op              = IN[OW-1:0];
  assign IMM             = op;
  assign REG_F_SEL       = op[REG_F_SEL_SIZE-1:0];
  assign D_MEM_ADDR      = op;
  assign BASE_REG_OFFSET = op;
  assign BASE_REG_DATA   = op;
  always_comb begin
    PC_RST          = 1'b0;
    PC_LD           = 1'b0;
    JMP_MODE        = 2'b00;
    ALU_OUT         = '0;
    IN_B_SEL        = '0;
    EN_REG_F        = 1'b0;
    D_MEM_ADDR_MODE = 1'b0;
    EN_D_MEM        = 1'b0;
    EN_ACC          = 1'b0;
    BASE_REG_LD     = 1'b0;
    LR_LD           = 1'b0;
    if (RST) PC_RST = 1'b1;
    else begin
      case (opc)
        OP_RST:  PC_RST = 1'b1;
        OP_LD:   begin IN_B_SEL = 2'b10; EN_ACC = 1'b1; end
        OP_ST:   EN_D_MEM = 1'b1;
        OP_LDR:  begin IN_B_SEL = 2'b01; EN_ACC = 1'b1; end
        OP_STR:  EN_REG_F = 1'b1;
        OP_BAR:  BASE_REG_LD = 1'b1;
        OP_JMP:  PC_LD = 1'b1;
        OP_JMPO: begin PC_LD = 1'b1; JMP_MODE = 2'b01; end
        OP_LDI:  EN_ACC = 1'b1;
        OP_LDAR: begin IN_B_SEL = 2'b10; D_MEM_ADDR_MODE = 1'b1; EN_ACC = 1'b1; end
        OP_XORR: begin IN_B_SEL = 2'b01; ALU_OUT = 4'd1; EN_ACC = 1'b1; end
        OP_ORR:  begin IN_B_SEL = 2'b01; ALU_OUT = 4'd2; EN_ACC = 1'b1; end
        OP_ANDR: begin IN_B_SEL = 2'b01; ALU_OUT = 4'd3; EN_ACC = 1'b1; end
        OP_ADDR: begin IN_B_SEL = 2'b01; ALU_OUT = 4'd4; EN_ACC = 1'b1; end
        OP_SUBR: begin IN_B_SEL = 2'b01; ALU_OUT = 4'd5; EN_ACC = 1'b1; end
        OP_CALL: begin PC_LD = 1'b1; LR_LD = 1'b1; end
        // A RET without a preceding CALL has no valid return address, so it decodes as NOP.
        OP_RET:  if (link_valid_q) begin PC_LD = 1'b1; JMP_MODE = 2'b10; end
        default: ;
      endcase
    end
  end
  assign link_valid_d = RST                                ? 1'b0 :
                        (opc == OP_CALL)                   ? 1'b1 :
                        (opc == OP_RET || opc == OP_RST)   ? 1'b0 : link_valid_q;
  always_ff @(posedge CLK) link_valid_q <= link_valid_d;
endmodule

// File: tb/tb_cpu_id.sv
// tb_cpu_id: directed-vector self-checking bench for cpu_id.
module tb_cpu_id;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [12:0] IN  = '0;
  logic        PC_RST, PC_LD, EN_REG_F, D_MEM_ADDR_MODE, EN_D_MEM, EN_ACC, BASE_REG_LD, LR_LD;
  logic [1:0]  JMP_MODE, IN_B_SEL;
  logic [3:0]  ALU_OUT, REG_F_SEL;
  logic [7:0]  IMM, D_MEM_ADDR, BASE_REG_OFFSET, BASE_REG_DATA;
  logic [15:0] ctrl;
  int          n_tests = 0;
  int          n_fail  = 0;
  cpu_id dut (
    .CLK(CLK), .RST(RST), .IN(IN), .PC_RST(PC_RST), .PC_LD(PC_LD), .JMP_MODE(JMP_MODE),
    .ALU_OUT(ALU_OUT), .IMM(IMM), .IN_B_SEL(IN_B_SEL), .REG_F_SEL(REG_F_SEL),
    .EN_REG_F(EN_REG_F), .D_MEM_ADDR(D_MEM_ADDR), .D_MEM_ADDR_MODE(D_MEM_ADDR_MODE),
    .EN_D_MEM(EN_D_MEM), .EN_ACC(EN_ACC), .BASE_REG_OFFSET(BASE_REG_OFFSET),
    .BASE_REG_LD(BASE_REG_LD), .BASE_REG_DATA(BASE_REG_DATA), .LR_LD(LR_LD)
  );
  always #5 CLK = ~CLK;
  assign ctrl = {PC_RST, PC_LD, JMP_MODE, ALU_OUT, IN_B_SEL, EN_REG_F, D_MEM_ADDR_MODE,
                 EN_D_MEM, EN_ACC, BASE_REG_LD, LR_LD};
  function automatic logic [15:0] mk(input logic pc_rst, pc_ld, input logic [1:0] jm,
                                     input logic [3:0] alu, input logic [1:0] bsel,
                                     input logic en_rf, dmode, en_dm, en_acc, brl, lr);
    return {pc_rst, pc_ld, jm, alu, bsel, en_rf, dmode, en_dm, en_acc, brl, lr};
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic apply(input logic [4:0] o, input logic [7:0] d);
    @(negedge CLK);
    IN = {o, d};
    #1;
  endtask
  task automatic chk_pt(input string tag, input logic [7:0] d);
    chk({tag, ".imm"}, 32'(IMM), 32'(d));
    chk({tag, ".dma"}, 32'(D_MEM_ADDR), 32'(d));
    chk({tag, ".bro"}, 32'(BASE_REG_OFFSET), 32'(d));
    chk({tag, ".brd"}, 32'(BASE_REG_DATA), 32'(d));
    chk({tag, ".rfs"}, 32'(REG_F_SEL), 32'(d[3:0]));
  endtask
  initial begin
    RST = 1'b1;
    apply(5'h09, 8'h0F);
    chk("rst_ldi", 32'(ctrl), 32'(mk(1,0,2'd0,4'd0,2'd0,0,0,0,0,0,0)));
    chk("rst_en_acc", 32'(EN_ACC), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("ldi", 32'(ctrl), 32'(mk(0,0,2'd0,4'd0,2'd0,0,0,0,1,0,0)));
    chk_pt("ldi", 8'h0F);
    apply(5'h00, 8'h00); chk("nop",  32'(ctrl), 32'(mk(0,0,2'd0,4'd0,2'd0,0,0,0,0,0,0)));
    apply(5'h01, 8'h00); chk("rsti", 32'(ctrl), 32'(mk(1,0,2'd0,4'd0,2'd0,0,0,0,0,0,0)));
    apply(5'h02, 8'h09); chk("ld",   32'(ctrl), 32'(mk(0,0,2'd0,4'd0,2'd2,0,0,0,1,0,0)));
    chk_pt("ld", 8'h09);
    apply(5'h03, 8'h06); chk("st",   32'(ctrl), 32'(mk(0,0,2'd0,4'd0,2'd0,0,0,1,0,0,0)));
    apply(5'h04, 8'h02); chk("ldr",  32'(ctrl), 32'(mk(0,0,2'd0,4'd0,2'd1,0,0,0,1,0,0)));
    apply(5'h05, 8'h07); chk("str",  32'(ctrl), 32'(mk(0,0,2'd0,4'd0,2'd0,1,0,0,0,0,0)));
    chk("str.rfs", 32'(REG_F_SEL), 32'd7);
    apply(5'h06, 8'hA1); chk("bar",  32'(ctrl), 32'(mk(0,0,2'd0,4'd0,2'd0,0,0,0,0,1,0)));
    chk_pt("bar", 8'hA1);
    apply(5'h07, 8'h2B); chk("jmp",  32'(ctrl), 32'(mk(0,1,2'd0,4'd0,2'd0,0,0,0,0,0,0)));
    apply(5'h08, 8'h0C); chk("jmpo", 32'(ctrl), 32'(mk(0,1,2'd1,4'd0,2'd0,0,0,0,0,0,0)));
    chk_pt("jmpo", 8'h0C);
    apply(5'h0A, 8'h02); chk("ldar", 32'(ctrl), 32'(mk(0,0,2'd0,4'd0,2'd2,0,1,0,1,0,0)));
    apply(5'h0B, 8'h01); chk("xorr", 32'(ctrl), 32'(mk(0,0,2'd0,4'd1,2'd1,0,0,0,1,0,0)));
    chk("xorr.rfs", 32'(REG_F_SEL), 32'd1);
    apply(5'h0C, 8'h03); chk("orr",  32'(ctrl), 32'(mk(0,0,2'd0,4'd2,2'd1,0,0,0,1,0,0)));
    chk("orr.rfs", 32'(REG_F_SEL), 32'd3);
    apply(5'h0D, 8'h04); chk("andr", 32'(ctrl), 32'(mk(0,0,2'd0,4'd3,2'd1,0,0,0,1,0,0)));
    chk("andr.rfs", 32'(REG_F_SEL), 32'd4);
    apply(5'h0E, 8'h05); chk("addr", 32'(ctrl), 32'(mk(0,0,2'd0,4'd4,2'd1,0,0,0,1,0,0)));
    chk("addr.rfs", 32'(REG_F_SEL), 32'd5);
    apply(5'h0F, 8'h06); chk("subr", 32'(ctrl), 32'(mk(0,0,2'd0,4'd5,2'd1,0,0,0,1,0,0)));
    chk("subr.rfs", 32'(REG_F_SEL), 32'd6);
    // link sequence: link flag is 0 here because the last write was the RST instruction
    apply(5'h11, 8'h00); chk("ret0",  32'(ctrl), 32'(mk(0,0,2'd0,4'd0,2'd0,0,0,0,0,0,0)));
    apply(5'h10, 8'h06); chk("call1", 32'(ctrl), 32'(mk(0,1,2'd0,4'd0,2'd0,0,0,0,0,0,1)));
    apply(5'h00, 8'h00); chk("nop_l", 32'(ctrl), 32'(mk(0,0,2'd0,4'd0,2'd0,0,0,0,0,0,0)));
    apply(5'h10, 8'h06); chk("call2", 32'(ctrl), 32'(mk(0,1,2'd0,4'd0,2'd0,0,0,0,0,0,1)));
    apply(5'h11, 8'h00); chk("ret1",  32'(ctrl), 32'(mk(0,1,2'd2,4'd0,2'd0,0,0,0,0,0,0)));
    apply(5'h11, 8'h00); chk("ret2",  32'(ctrl), 32'(mk(0,0,2'd0,4'd0,2'd0,0,0,0,0,0,0)));
    apply(5'h10, 8'h06);
    apply(5'h00, 8'h00);
    apply(5'h11, 8'h00); chk("ret_nop_hold", 32'(ctrl), 32'(mk(0,1,2'd2,4'd0,2'd0,0,0,0,0,0,0)));
    apply(5'h10, 8'h06);
    @(negedge CLK);
    RST = 1'b1;
    #1;
    chk("rst_mid", 32'(ctrl), 32'(mk(1,0,2'd0,4'd0,2'd0,0,0,0,0,0,0)));
    @(negedge CLK);
    RST = 1'b0;
    IN = {5'h11, 8'h00};
    #1;
    chk("ret_after_rst", 32'(ctrl), 32'(mk(0,0,2'd0,4'd0,2'd0,0,0,0,0,0,0)));
    apply(5'h10, 8'h06);
    apply(5'h01, 8'h00);
    apply(5'h11, 8'h00); chk("ret_after_rsti", 32'(ctrl), 32'(mk(0,0,2'd0,4'd0,2'd0,0,0,0,0,0,0)));
    apply(5'h1F, 8'hFF); chk("resv", 32'(ctrl), 32'(mk(0,0,2'd0,4'd0,2'd0,0,0,0,0,0,0)));
    chk_pt("resv", 8'hFF);
    apply(5'h12, 8'h5A); chk("resv12", 32'(ctrl), 32'(mk(0,0,2'd0,4'd0,2'd0,0,0,0,0,0,0)));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
